// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and reports each completion on a single-cycle response strobe.
// A wait-state timeout aborts transfers to a slave that never raises pready.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  // Value of the wait counter during the last permitted low-pready ACCESS cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          done;
  logic          abort;

  // Handshake and transfer-end decode from the current state.
  always_comb begin
    done      = (state == ACCESS) && pready;
    // The counter holds the number of low-pready ACCESS cycles already seen,
    // so the TIMEOUT-th low cycle is the one where it equals TIMEOUT-1.
    abort     = (state == ACCESS) && !pready && (wait_cnt == LAST_WAIT);
    cmd_ready = (state == IDLE) || done;
    accept    = cmd_valid && cmd_ready;
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
  end

  // Phase sequencing and wait-state counting.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state <= SETUP;
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (pready) begin
            state <= accept ? SETUP : IDLE;
          end else if (abort) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Bus address/direction/data capture; held steady between accepts.
  always_ff @(posedge pclk) begin
    if (rst) begin
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (accept) begin
      paddr  <= cmd_addr;
      pwrite <= cmd_write;
      pwdata <= cmd_wdata;
    end
  end

  // Response strobe; data and error hold until the next response.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || abort;
      if (done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed scenarios plus randomized
// transfers against a transaction-level model of the slave memory.
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] paddr;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Storage seen by the emulated slave (driven from the DUT's bus pins)
  // and the model's view of what each address should hold.
  logic [DW-1:0] slave_mem [256];
  logic [DW-1:0] model_mem [256];

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic garbage_cmd();
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
  endtask

  // Slave completes this cycle: reads return stored data, writes update storage.
  task automatic slave_complete();
    pready = 1'b1;
    if (pwrite) begin
      prdata = $urandom;
      slave_mem[paddr] = pwdata;
    end else begin
      prdata = slave_mem[paddr];
    end
  endtask

  // One isolated transfer with `waits` low-pready ACCESS cycles (>= TO means abort).
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits);
    bit            to;
    int            n_acc;
    logic [DW-1:0] exp_rd;
    to     = (waits >= TO);
    n_acc  = to ? TO : waits + 1;
    exp_rd = (wr || to) ? '0 : model_mem[a];

    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    pready = 1'($urandom); prdata = $urandom;
    #1;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_psel", psel, 0);

    @(negedge pclk);
    cmd_valid = 1'($urandom); garbage_cmd();
    pready = 1'($urandom); prdata = $urandom;
    #1;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_ready", cmd_ready, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, d);

    for (int i = 0; i < n_acc; i++) begin
      @(negedge pclk);
      cmd_valid = 1'b0; garbage_cmd();
      if (!to && i == waits) slave_complete();
      else begin pready = 1'b0; prdata = $urandom; end
      #1;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwrite", pwrite, wr);
      chk("access_pwdata", pwdata, d);
      chk("access_ready", cmd_ready, pready);
      chk("access_rsp_quiet", rsp_valid, 0);
    end

    @(negedge pclk);
    cmd_valid = 1'b0; pready = 1'($urandom); prdata = $urandom;
    #1;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, to);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    chk("rsp_ready", cmd_ready, 1);
    if (wr && !to) model_mem[a] = d;

    @(negedge pclk);
    #1;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_rsp_rdata_hold", rsp_rdata, exp_rd);
    chk("post_rsp_err_hold", rsp_err, to);
  endtask

  // Two zero-wait transfers with the second offered during the first's ACCESS.
  task automatic b2b(input bit wr1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input bit wr2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    exp1 = wr1 ? '0 : model_mem[a1];
    if (wr1) model_mem[a1] = d1;
    exp2 = wr2 ? '0 : model_mem[a2];
    if (wr2) model_mem[a2] = d2;

    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr1; cmd_addr = a1; cmd_wdata = d1; pready = 1'b0;
    #1;
    chk("b2b_idle_ready", cmd_ready, 1);

    @(negedge pclk);
    cmd_valid = 1'b0; garbage_cmd(); pready = 1'b0;
    #1;
    chk("b2b_setup1_psel", psel, 1);
    chk("b2b_setup1_penable", penable, 0);

    @(negedge pclk);
    slave_complete();
    cmd_valid = 1'b1; cmd_write = wr2; cmd_addr = a2; cmd_wdata = d2;
    #1;
    chk("b2b_access1_penable", penable, 1);
    chk("b2b_access1_paddr", paddr, a1);
    chk("b2b_access1_ready", cmd_ready, 1);

    @(negedge pclk);
    cmd_valid = 1'b0; garbage_cmd(); pready = 1'b0;
    #1;
    chk("b2b_setup2_psel", psel, 1);
    chk("b2b_setup2_penable", penable, 0);
    chk("b2b_setup2_paddr", paddr, a2);
    chk("b2b_setup2_pwrite", pwrite, wr2);
    chk("b2b_setup2_pwdata", pwdata, d2);
    chk("b2b_rsp1_valid", rsp_valid, 1);
    chk("b2b_rsp1_rdata", rsp_rdata, exp1);
    chk("b2b_rsp1_err", rsp_err, 0);

    @(negedge pclk);
    slave_complete();
    #1;
    chk("b2b_access2_penable", penable, 1);
    chk("b2b_access2_rsp_quiet", rsp_valid, 0);

    @(negedge pclk);
    pready = 1'b0;
    #1;
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_rdata", rsp_rdata, exp2);
    chk("b2b_rsp2_psel", psel, 0);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      model_mem[i] = v;
    end

    rst = 1'b1; cmd_valid = 1'b0; garbage_cmd(); pready = 1'b0; prdata = '0;
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge pclk);
    rst = 1'b0;

    // Directed: write, read with three waits, boundary completion, timeout.
    xfer(1'b1, 8'h10, 32'hDEADBEEF, 0);
    xfer(1'b0, 8'h10, 32'h0, 3);
    xfer(1'b0, 8'h10, 32'h0, TO - 1);
    xfer(1'b1, 8'h20, 32'h12345678, TO);
    xfer(1'b0, 8'h20, 32'h0, TO);

    b2b(1'b1, 8'h04, 32'hA5A5A5A5, 1'b1, 8'h08, 32'h5A5A5A5A);
    b2b(1'b0, 8'h04, 32'h0, 1'b0, 8'h08, 32'h0);

    // Reset during an ACCESS wait state aborts silently.
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'hCAFEF00D; pready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0; garbage_cmd();
    @(negedge pclk);
    pready = 1'b0;
    #1;
    chk("rst_mid_access", penable, 1);
    rst = 1'b1;
    @(negedge pclk);
    #1;
    chk("rst_mid_psel", psel, 0);
    chk("rst_mid_penable", penable, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_paddr", paddr, 0);
    rst = 1'b0;
    @(negedge pclk);
    #1;
    chk("rst_mid_no_rsp", rsp_valid, 0);
    xfer(1'b0, 8'h30, 32'h0, 1);

    // Idle with cmd_valid low: nothing happens on the bus or response.
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      cmd_valid = 1'b0; garbage_cmd(); pready = 1'($urandom); prdata = $urandom;
      #1;
      chk("idle_hold_psel", psel, 0);
      chk("idle_hold_rsp", rsp_valid, 0);
    end

    // Randomized transfers, including boundary and timeout wait counts.
    for (int i = 0; i < 40; i++) begin
      int r;
      int w;
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 4);
      else if (r < 8) w = TO - 1;
      else            w = TO;
      xfer(1'($urandom), AW'($urandom_range(0, 15)), $urandom, w);
      if (i % 10 == 0)
        b2b(1'($urandom), AW'($urandom_range(0, 15)), $urandom,
            1'($urandom), AW'($urandom_range(0, 15)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester: converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers toward the existing apb_slave.
- Returns read data and completion status on a one-cycle response strobe.
- Sits between test or CPU-side logic and the APB bus, driving the same PADDR/PSEL/PENABLE/PWRITE/PWDATA signals that apb_slave consumes.
- Includes a wait-state timeout so a hung slave cannot stall the requester.

Parameters:
ADDR_WIDTH, 8, width of paddr and cmd_addr
DATA_WIDTH, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata
TIMEOUT, 16, max ACCESS cycles with pready low before abort (>=1)

Ports:
pclk  input  1  APB clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready at rising edge
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts)
rsp_err  output  1  1 = transfer aborted by timeout
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
pready  input  1  APB ready from slave
prdata  input  DATA_WIDTH  APB read data

Behaviour:
- Interface decided: one clock pclk; reset rst is synchronous and active-high.
- Reset (rst=1 at edge): state IDLE. psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Reset mid-transfer aborts the transfer immediately with no rsp_valid.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1.
  - On accept, register cmd_addr/cmd_write/cmd_wdata into paddr/pwrite/pwdata and go to SETUP.
  - No accept: bus outputs hold their previous values, psel=0.
- SETUP (one cycle): psel=1, penable=0. Next state is always ACCESS; counter cleared.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stable through the whole transfer.
  - pready=1 at edge: complete. Next cycle rsp_valid=1, rsp_err=0, rsp_rdata=prdata for reads, 0 for writes.
  - pready=0: increment counter. If the counter reaches TIMEOUT with pready still 0, abort:
    - psel=0, penable=0 next cycle, state IDLE.
    - rsp_valid=1, rsp_err=1, rsp_rdata=0.
- cmd_ready in ACCESS equals pready (combinational), allowing back-to-back transfers.
  - If a command is accepted at completion, next state is SETUP: psel stays 1, penable=0, new address/data loaded.
  - Otherwise next state is IDLE.
- cmd_ready=0 in SETUP and in the ACCESS abort cycle.
- Latency:
  - Accept at edge N gives SETUP in cycle N+1 and ACCESS in N+2.
  - Zero-wait completion at edge N+2; rsp_valid during cycle N+3.
  - Each wait state adds 1 cycle.
- rsp_valid has no backpressure: it is a single-cycle pulse and rsp_rdata/rsp_err hold until the next response.
- cmd_* fields are ignored when no accept occurs.
- The counter saturates logic must not wrap; a width of clog2(TIMEOUT+1) is sufficient.

Test Plan:
- Reset then single write addr=0x10, data=0xDEADBEEF, pready tied 1 -> SETUP at cycle 1 (psel=1, penable=0), ACCESS at cycle 2, rsp_valid at cycle 3 with rsp_err=0, rsp_rdata=0.
- Read addr=0x10, slave returns prdata=0xDEADBEEF after 3 wait states -> penable held 1 for 4 cycles, paddr stable, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Back-to-back: cmd_valid held with writes to 0x04 then 0x08, pready=1 -> second SETUP directly follows the first ACCESS with psel never deasserting; two rsp_valid pulses 2 cycles apart.
- Timeout: pready held 0, TIMEOUT=16 -> after 16 ACCESS cycles psel/penable drop to 0, rsp_valid=1, rsp_err=1, rsp_rdata=0, cmd_ready returns to 1.
- Reset asserted during ACCESS with a wait state -> next cycle psel=0, penable=0, no rsp_valid; a new command afterwards completes normally.
- cmd_valid=0 throughout -> psel stays 0 and rsp_valid stays 0 indefinitely.
